// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request/ready data-memory access, load formatting, MEM/WB register.
// Define RISCV_DMEM_TIMEOUT_EN to enable the ACCESS timeout and mem_bus_err reporting.
module mem_access_unit #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DMEM_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
  input  logic [2:0]                EX_MEM_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_reg_write_en,
  input  logic                      EX_MEM_mem_write_en,
  input  logic                      EX_MEM_mem_read_en,
  input  logic                      EX_MEM_wb_sel,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [REG_WIDTH-1:0]      dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [REG_WIDTH-1:0]      dmem_wdata,
  input  logic                      dmem_ready,
  input  logic [REG_WIDTH-1:0]      dmem_rdata,
  output logic                      mem_stall,
  output logic                      mem_misalign,
  output logic                      mem_bus_err,
  output logic [REG_WIDTH-1:0]      MEM_WB_wb_data,
  output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  output logic                      MEM_WB_reg_write_en
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e                    state_q, state_d;
  logic                      dmem_req_q, dmem_req_d;
  logic                      dmem_we_q, dmem_we_d;
  logic [REG_WIDTH-1:0]      dmem_addr_q, dmem_addr_d;
  logic [3:0]                dmem_be_q, dmem_be_d;
  logic [REG_WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic [1:0]                off_q, off_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wb_sel_q, wb_sel_d;
  logic                      rwe_q, rwe_d;
  logic [REG_WIDTH-1:0]      wb_data_q, wb_data_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic                      wb_we_q, wb_we_d;
  logic                      misalign_q, misalign_d;
  logic                      stall;

  logic                      mem_op;
  logic                      misaligned;
  logic [3:0]                st_be;
  logic [REG_WIDTH-1:0]      st_wdata;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [REG_WIDTH-1:0]      ld_data;

`ifdef RISCV_DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(DMEM_TIMEOUT + 1) > 8) ? $clog2(DMEM_TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  // Request decode, alignment and store lane steering from the live EX/MEM fields.
  always_comb begin
    mem_op = EX_MEM_mem_read_en | EX_MEM_mem_write_en;
    case (EX_MEM_funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        st_be      = 4'b0001 << EX_MEM_alu_out[1:0];
        st_wdata   = {(REG_WIDTH/8){EX_MEM_dataB[7:0]}};
      end
      2'b01: begin
        misaligned = EX_MEM_alu_out[0];
        st_be      = 4'b0011 << {EX_MEM_alu_out[1], 1'b0};
        st_wdata   = {(REG_WIDTH/16){EX_MEM_dataB[15:0]}};
      end
      default: begin
        misaligned = |EX_MEM_alu_out[1:0];
        st_be      = 4'b1111;
        st_wdata   = EX_MEM_dataB;
      end
    endcase
  end

  // Load formatting uses the offset/size captured on ACCESS entry.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(REG_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(REG_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    wb_sel_d     = wb_sel_q;
    rwe_d        = rwe_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    misalign_d   = 1'b0;
    stall        = 1'b0;
`ifdef RISCV_DMEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_op && !misaligned) begin
          state_d      = S_ACCESS;
          stall        = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = EX_MEM_mem_write_en;
          dmem_addr_d  = {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
          dmem_be_d    = st_be;
          dmem_wdata_d = st_wdata;
          off_d        = EX_MEM_alu_out[1:0];
          funct3_d     = EX_MEM_funct3;
          rd_d         = EX_MEM_rd;
          wb_sel_d     = EX_MEM_wb_sel;
          rwe_d        = EX_MEM_reg_write_en;
          wb_data_d    = '0;
          wb_rd_d      = '0;
          wb_we_d      = 1'b0;
`ifdef RISCV_DMEM_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else if (mem_op) begin
          misalign_d = 1'b1;
          wb_data_d  = '0;
          wb_rd_d    = '0;
          wb_we_d    = 1'b0;
        end else begin
          wb_data_d  = EX_MEM_alu_out;
          wb_rd_d    = EX_MEM_rd;
          wb_we_d    = EX_MEM_reg_write_en;
        end
      end
      S_ACCESS: begin
        stall = ~dmem_ready;
        if (dmem_ready) begin
          state_d      = S_IDLE;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = '0;
          dmem_be_d    = '0;
          dmem_wdata_d = '0;
          // ALU result is rebuilt from the held word address plus captured offset.
          wb_data_d    = wb_sel_q ? ld_data : {dmem_addr_q[REG_WIDTH-1:2], off_q};
          wb_rd_d      = rd_q;
          wb_we_d      = rwe_q;
        end
`ifdef RISCV_DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(DMEM_TIMEOUT - 1)) begin
          state_d      = S_IDLE;
          stall        = 1'b0;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = '0;
          dmem_be_d    = '0;
          dmem_wdata_d = '0;
          wb_data_d    = '0;
          wb_rd_d      = '0;
          wb_we_d      = 1'b0;
          bus_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      wb_sel_q     <= 1'b0;
      rwe_q        <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      wb_sel_q     <= wb_sel_d;
      rwe_q        <= rwe_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef RISCV_DMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_bus_err = bus_err_q;
`else
  assign mem_bus_err = 1'b0;
`endif

  // Stall is combinational from state; mask it so reset forces every output low at once.
  assign mem_stall           = stall & ~reset;
  assign dmem_req            = dmem_req_q;
  assign dmem_we             = dmem_we_q;
  assign dmem_addr           = dmem_addr_q;
  assign dmem_be             = dmem_be_q;
  assign dmem_wdata          = dmem_wdata_q;
  assign mem_misalign        = misalign_q;
  assign MEM_WB_wb_data      = wb_data_q;
  assign MEM_WB_rd           = wb_rd_q;
  assign MEM_WB_reg_write_en = wb_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, write-back scoreboard, reset and timeout sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] EX_MEM_alu_out;
  logic [31:0] EX_MEM_dataB;
  logic [2:0]  EX_MEM_funct3;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_reg_write_en;
  logic        EX_MEM_mem_write_en;
  logic        EX_MEM_mem_read_en;
  logic        EX_MEM_wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_bus_err;
  logic [31:0] MEM_WB_wb_data;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_reg_write_en;

  mem_access_unit #(
    .REG_WIDTH      (32),
    .REG_ADDR_WIDTH (5),
    .DMEM_TIMEOUT   (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_MEM_alu_out      (EX_MEM_alu_out),
    .EX_MEM_dataB        (EX_MEM_dataB),
    .EX_MEM_funct3       (EX_MEM_funct3),
    .EX_MEM_rd           (EX_MEM_rd),
    .EX_MEM_reg_write_en (EX_MEM_reg_write_en),
    .EX_MEM_mem_write_en (EX_MEM_mem_write_en),
    .EX_MEM_mem_read_en  (EX_MEM_mem_read_en),
    .EX_MEM_wb_sel       (EX_MEM_wb_sel),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_be             (dmem_be),
    .dmem_wdata          (dmem_wdata),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .mem_misalign        (mem_misalign),
    .mem_bus_err         (mem_bus_err),
    .MEM_WB_wb_data      (MEM_WB_wb_data),
    .MEM_WB_rd           (MEM_WB_rd),
    .MEM_WB_reg_write_en (MEM_WB_reg_write_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] datab;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rwe;
    logic        mwe;
    logic        mre;
    logic        wbsel;
    int          waits;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } sb_t;

  int   errors = 0;
  int   checks = 0;
  sb_t  sb[$];
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] datab, input logic [2:0] f3,
                              input logic [4:0] rd, input logic rwe, input logic mwe, input logic mre,
                              input logic wbsel, input int waits, input logic [31:0] rdata,
                              input logic exp_mis, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    vec_t v;
    v.alu = alu; v.datab = datab; v.f3 = f3; v.rd = rd; v.rwe = rwe; v.mwe = mwe; v.mre = mre;
    v.wbsel = wbsel; v.waits = waits; v.rdata = rdata; v.exp_mis = exp_mis; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_wb = exp_wb;
    return v;
  endfunction

  task automatic drive_nop();
    EX_MEM_alu_out      = '0;
    EX_MEM_dataB        = '0;
    EX_MEM_funct3       = '0;
    EX_MEM_rd           = '0;
    EX_MEM_reg_write_en = 1'b0;
    EX_MEM_mem_write_en = 1'b0;
    EX_MEM_mem_read_en  = 1'b0;
    EX_MEM_wb_sel       = 1'b0;
  endtask

  // Called at a falling edge; one idle cycle, then pulse outputs must be low.
  task automatic nop_cycle();
    drive_nop();
    @(negedge clk);
    chk("nop_misalign", mem_misalign, 0);
    chk("nop_bus_err", mem_bus_err, 0);
    chk("nop_req", dmem_req, 0);
    chk("nop_stall", mem_stall, 0);
  endtask

  task automatic pop_check(input int idx);
    sb_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty v%0d: got empty queue expected entry", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("wb_we v%0d", idx), MEM_WB_reg_write_en, e.we);
    if (e.we) begin
      chk($sformatf("wb_data v%0d", idx), MEM_WB_wb_data, e.data);
      chk($sformatf("wb_rd v%0d", idx), MEM_WB_rd, e.rd);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after MEM_WB captured the op.
  task automatic do_op(input vec_t v, input int idx);
    sb_t e;
    logic memop;
    memop = v.mwe | v.mre;
    EX_MEM_alu_out      = v.alu;
    EX_MEM_dataB        = v.datab;
    EX_MEM_funct3       = v.f3;
    EX_MEM_rd           = v.rd;
    EX_MEM_reg_write_en = v.rwe;
    EX_MEM_mem_write_en = v.mwe;
    EX_MEM_mem_read_en  = v.mre;
    EX_MEM_wb_sel       = v.wbsel;
    dmem_ready          = 1'b0;
    dmem_rdata          = $urandom;
    e.data = v.exp_wb;
    e.rd   = v.rd;
    e.we   = v.exp_mis ? 1'b0 : v.rwe;
    sb.push_back(e);
    #1;
    if (!memop) begin
      chk($sformatf("alu_stall v%0d", idx), mem_stall, 0);
      @(negedge clk);
    end else if (v.exp_mis) begin
      chk($sformatf("mis_stall v%0d", idx), mem_stall, 0);
      @(negedge clk);
      chk($sformatf("mis_pulse v%0d", idx), mem_misalign, 1);
      chk($sformatf("mis_req v%0d", idx), dmem_req, 0);
    end else begin
      chk($sformatf("idle_stall v%0d", idx), mem_stall, 1);
      @(negedge clk);
      chk($sformatf("req v%0d", idx), dmem_req, 1);
      chk($sformatf("addr v%0d", idx), dmem_addr, v.exp_addr);
      chk($sformatf("we v%0d", idx), dmem_we, v.mwe);
      chk($sformatf("misalign_low v%0d", idx), mem_misalign, 0);
      if (v.mwe) begin
        chk($sformatf("be v%0d", idx), dmem_be, v.exp_be);
        chk($sformatf("wdata v%0d", idx), dmem_wdata, v.exp_wdata);
      end
      for (int w = 0; w < v.waits; w++) begin
        chk($sformatf("wait_stall v%0d", idx), mem_stall, 1);
        dmem_rdata = $urandom;
        @(negedge clk);
        chk($sformatf("hold_addr v%0d", idx), dmem_addr, v.exp_addr);
      end
      dmem_ready = 1'b1;
      dmem_rdata = v.rdata;
      #1;
      chk($sformatf("ready_stall v%0d", idx), mem_stall, 0);
      chk($sformatf("ready_req v%0d", idx), dmem_req, 1);
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      chk($sformatf("req_drop v%0d", idx), dmem_req, 0);
    end
    pop_check(idx);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            alu           datab         f3      rd  rwe mwe mre wbs wt rdata         mis addr          be       wdata         wb
    vecs[0]  = mk(32'h0000_1234, 32'h0,        3'b000, 5,  1,  0,  0,  0,  0, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        32'h0000_1234);
    vecs[1]  = mk(32'h0000_0103, 32'h1234_56AB, 3'b000, 0,  0,  1,  0,  0,  0, 32'h0,        0,  32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0);
    vecs[2]  = mk(32'h0000_0102, 32'h0,        3'b001, 7,  1,  0,  1,  1,  3, 32'h8001_7FFF, 0,  32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8001);
    vecs[3]  = mk(32'h0000_0102, 32'h0,        3'b101, 8,  1,  0,  1,  1,  3, 32'h8001_7FFF, 0,  32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8001);
    vecs[4]  = mk(32'h0000_0101, 32'h0,        3'b010, 10, 1,  0,  1,  1,  0, 32'h0,        1,  32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[5]  = mk(32'h0000_0101, 32'h0,        3'b000, 11, 1,  0,  1,  1,  1, 32'h0000_80FF, 0,  32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80);
    vecs[6]  = mk(32'h0000_0103, 32'h0,        3'b100, 12, 1,  0,  1,  1,  0, 32'hF100_0000, 0,  32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00F1);
    vecs[7]  = mk(32'h0000_0106, 32'h0000_BEEF, 3'b001, 0,  0,  1,  0,  0,  2, 32'h0,        0,  32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    vecs[8]  = mk(32'h0000_0208, 32'hDEAD_BEEF, 3'b010, 0,  0,  1,  0,  0,  0, 32'h0,        0,  32'h0000_0208, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[9]  = mk(32'h0000_020C, 32'h0,        3'b010, 31, 1,  0,  1,  1,  1, 32'hCAFE_F00D, 0,  32'h0000_020C, 4'b0000, 32'h0,        32'hCAFE_F00D);
    vecs[10] = mk(32'h0000_00FF, 32'h0000_1111, 3'b001, 0,  0,  1,  0,  0,  0, 32'h0,        1,  32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(32'h0000_0012, 32'h0000_005A, 3'b000, 0,  0,  1,  1,  0,  0, 32'h0,        0,  32'h0000_0010, 4'b0100, 32'h5A5A_5A5A, 32'h0);
    vecs[12] = mk(32'hFFFF_FFFF, 32'h0,        3'b000, 31, 1,  0,  0,  0,  0, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        32'hFFFF_FFFF);
    vecs[13] = mk(32'h0000_0102, 32'h0,        3'b011, 2,  1,  0,  1,  1,  0, 32'h0,        1,  32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[14] = mk(32'h0000_0101, 32'h0,        3'b101, 2,  1,  0,  1,  1,  0, 32'h0,        1,  32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[15] = mk(32'h0000_0100, 32'h0,        3'b001, 3,  1,  0,  1,  1,  0, 32'h1234_F00F, 0,  32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_F00F);
    vecs[16] = mk(32'h0000_0044, 32'h0,        3'b010, 4,  1,  0,  1,  0,  0, 32'h9999_9999, 0,  32'h0000_0044, 4'b0000, 32'h0,        32'h0000_0044);

    reset      = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_misalign", mem_misalign, 0);
    chk("rst_bus_err", mem_bus_err, 0);
    chk("rst_wb_data", MEM_WB_wb_data, 0);
    chk("rst_wb_rd", MEM_WB_rd, 0);
    chk("rst_wb_we", MEM_WB_reg_write_en, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i], i);
      nop_cycle();
    end

    // Back-to-back memory ops: the second is presented on the completing edge of the first.
    do_op(vecs[9], 100);
    do_op(vecs[8], 101);
    do_op(vecs[2], 102);
    nop_cycle();

    // Asynchronous reset in the middle of a waiting access.
    EX_MEM_alu_out      = 32'h0000_0300;
    EX_MEM_funct3       = 3'b010;
    EX_MEM_rd           = 5'd9;
    EX_MEM_reg_write_en = 1'b1;
    EX_MEM_mem_read_en  = 1'b1;
    EX_MEM_wb_sel       = 1'b1;
    dmem_ready          = 1'b0;
    @(negedge clk);
    chk("mid_req", dmem_req, 1);
    chk("mid_stall", mem_stall, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", mem_stall, 0);
    chk("arst_addr", dmem_addr, 0);
    chk("arst_wb_data", MEM_WB_wb_data, 0);
    chk("arst_wb_rd", MEM_WB_rd, 0);
    chk("arst_wb_we", MEM_WB_reg_write_en, 0);
    drive_nop();
    @(negedge clk);
    reset = 1'b0;
    nop_cycle();
    do_op(vecs[5], 200);
    nop_cycle();
    do_op(vecs[0], 201);
    nop_cycle();

`ifdef RISCV_DMEM_TIMEOUT_EN
    // Memory never answers: four ACCESS cycles, then bus error and bubble.
    EX_MEM_alu_out      = 32'h0000_0040;
    EX_MEM_funct3       = 3'b010;
    EX_MEM_rd           = 5'd6;
    EX_MEM_reg_write_en = 1'b1;
    EX_MEM_mem_read_en  = 1'b1;
    EX_MEM_wb_sel       = 1'b1;
    dmem_ready          = 1'b0;
    #1;
    chk("to_idle_stall", mem_stall, 1);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_req c%0d", k), dmem_req, 1);
      chk($sformatf("to_stall c%0d", k), mem_stall, (k < 4) ? 1 : 0);
      chk($sformatf("to_err_low c%0d", k), mem_bus_err, 0);
      if (k < 4) @(negedge clk);
    end
    drive_nop();
    @(negedge clk);
    chk("to_bus_err", mem_bus_err, 1);
    chk("to_req_drop", dmem_req, 0);
    chk("to_bubble", MEM_WB_reg_write_en, 0);
    nop_cycle();
    do_op(vecs[9], 300);
    nop_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
